// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_IO   = 1'b1
  } owner_t;

  // Supported RAM read latency range, in cycles.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Wide enough to hold RD_LAT_MAX-2 wait cycles.
  localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/dmem_arb_lat_cnt.sv
// Read-latency down counter: loaded on ISSUE, counts WAIT cycles down to zero.
module dmem_arb_lat_cnt
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 done
);

  logic [LAT_CNT_W-1:0] cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LAT_CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the core MEM stage
// and the loader (IO) port, with one access in flight at a time.
// Optional feature: define DMEM_ARB_SHARED_EN to let IO compete inside the
// core run window, with round-robin arbitration on simultaneous requests.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_start,
  input  logic              core_end,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_memory_mem,
  output logic [31:0]       data_from_memory_mem,
  output logic              data_ready_mem,
  input  logic              memread_io,
  input  logic              memwrite_io,
  input  logic [31:0]       addr_io,
  input  logic [31:0]       write_data_io,
  output logic [31:0]       data_from_memory_io,
  output logic              data_ready_io,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT out of range");
  end

  // WAIT lasts RD_LAT-1 cycles; the counter reaches zero on the last one.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
    (RD_LAT >= 2) ? LAT_CNT_W'(RD_LAT - 2) : '0;

  arb_state_t  state, state_nxt;
  owner_t      owner, grant_owner;
  logic        op_we;
  logic        core_req, io_req, run_win, core_elig, io_elig, grant;
  logic        cnt_load, cnt_dec, cnt_done;
  logic        resp_core, resp_io, resp_rd, core_busy;
  logic [31:0] rdata_core, rdata_io;

  // Word index only: byte offset and bits above the RAM size wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_result_mem[1:0], alu_result_mem[31:ADDR_W+2],
                              addr_io[1:0], addr_io[31:ADDR_W+2]};

  assign core_req  = memread_mem | memwrite_mem;
  assign io_req    = memread_io | memwrite_io;
  assign run_win   = core_start & ~core_end;
  assign core_elig = core_req & run_win;
`ifdef DMEM_ARB_SHARED_EN
  assign io_elig   = io_req;
`else
  assign io_elig   = io_req & ~run_win;
`endif
  assign grant     = core_elig | io_elig;

`ifdef DMEM_ARB_SHARED_EN
  owner_t rr_next;

  // Round-robin pointer: the owner not granted last goes first on contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_next <= OWN_CORE;
    end else if (state == IDLE && grant) begin
      rr_next <= (grant_owner == OWN_CORE) ? OWN_IO : OWN_CORE;
    end
  end
`endif

  // Choose which requester owns the next access.
  always_comb begin
    grant_owner = OWN_CORE;
`ifdef DMEM_ARB_SHARED_EN
    if (core_elig && io_elig) begin
      grant_owner = rr_next;
    end else if (io_elig) begin
      grant_owner = OWN_IO;
    end
`else
    if (!core_elig && io_elig) begin
      grant_owner = OWN_IO;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and RAM/response strobes.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    resp_core = 1'b0;
    resp_io   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        ram_en = 1'b1;
        ram_we = op_we;
        if (op_we || RD_LAT == 1) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_load  = 1'b1;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_nxt = RESP;
      end
      RESP: begin
        resp_core = (owner == OWN_CORE);
        resp_io   = (owner == OWN_IO);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dmem_arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Latch owner, operation, word address and write data on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_CORE;
      op_we     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (state == IDLE && grant) begin
      owner <= grant_owner;
      if (grant_owner == OWN_CORE) begin
        op_we     <= memwrite_mem;
        ram_addr  <= alu_result_mem[ADDR_W+1:2];
        ram_wdata <= write_data_memory_mem;
      end else begin
        op_we     <= memwrite_io;
        ram_addr  <= addr_io[ADDR_W+1:2];
        ram_wdata <= write_data_io;
      end
    end
  end

  // Read data arrives in RESP; keep it per owner until that owner's next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_core <= '0;
      rdata_io   <= '0;
    end else if (resp_rd) begin
      if (owner == OWN_CORE) rdata_core <= ram_rdata;
      else                   rdata_io   <= ram_rdata;
    end
  end

  assign resp_rd   = (state == RESP) && !op_we;
  assign core_busy = (state != IDLE) && (owner == OWN_CORE);

  // During RESP the fresh RAM word is forwarded so it is valid with data_ready.
  assign data_from_memory_mem = (resp_rd && owner == OWN_CORE) ? ram_rdata : rdata_core;
  assign data_from_memory_io  = (resp_rd && owner == OWN_IO)   ? ram_rdata : rdata_io;

  // An idle core (no request, nothing in flight) must never see a stall.
  assign data_ready_mem = ~rst & (resp_core | (~core_req & ~core_busy));
  assign data_ready_io  = resp_io;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with a
// behavioural RAM, checked against a shadow-memory reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int NI     = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  logic              core_start [NI], core_end [NI];
  logic              memread_mem [NI], memwrite_mem [NI];
  logic [31:0]       alu_result_mem [NI], write_data_memory_mem [NI];
  logic [31:0]       data_from_memory_mem [NI];
  logic              data_ready_mem [NI];
  logic              memread_io [NI], memwrite_io [NI];
  logic [31:0]       addr_io [NI], write_data_io [NI];
  logic [31:0]       data_from_memory_io [NI];
  logic              data_ready_io [NI];
  logic              ram_en [NI], ram_we [NI];
  logic [ADDR_W-1:0] ram_addr [NI];
  logic [31:0]       ram_wdata [NI], ram_rdata [NI];

  // Environment RAM and access monitor.
  logic [31:0]       ram_mem [NI][DEPTH];
  logic [31:0]       pipe [NI][3];
  int                en_cnt [NI] = '{0, 0};
  logic [ADDR_W-1:0] last_addr [NI];
  logic              last_we [NI];
  logic [31:0]       last_wdata [NI];

  // Reference model: what each RAM should hold, and which words are known.
  logic [31:0] shadow [NI][DEPTH];
  int          written [NI][$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int rl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .core_start            (core_start[g]),
      .core_end              (core_end[g]),
      .memread_mem           (memread_mem[g]),
      .memwrite_mem          (memwrite_mem[g]),
      .alu_result_mem        (alu_result_mem[g]),
      .write_data_memory_mem (write_data_memory_mem[g]),
      .data_from_memory_mem  (data_from_memory_mem[g]),
      .data_ready_mem        (data_ready_mem[g]),
      .memread_io            (memread_io[g]),
      .memwrite_io           (memwrite_io[g]),
      .addr_io               (addr_io[g]),
      .write_data_io         (write_data_io[g]),
      .data_from_memory_io   (data_from_memory_io[g]),
      .data_ready_io         (data_ready_io[g]),
      .ram_en                (ram_en[g]),
      .ram_we                (ram_we[g]),
      .ram_addr              (ram_addr[g]),
      .ram_wdata             (ram_wdata[g]),
      .ram_rdata             (ram_rdata[g])
    );
  end

  // RAM with RD_LAT-cycle read pipeline; invalid slots carry a poison word.
  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      if (ram_en[d] && ram_we[d]) ram_mem[d][ram_addr[d]] <= ram_wdata[d];
      pipe[d][0] <= (ram_en[d] && !ram_we[d]) ? ram_mem[d][ram_addr[d]] : 32'hBAD0BAD0;
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
      if (ram_en[d]) begin
        en_cnt[d]     <= en_cnt[d] + 1;
        last_addr[d]  <= ram_addr[d];
        last_we[d]    <= ram_we[d];
        last_wdata[d] <= ram_wdata[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NI; d++) ram_rdata[d] = pipe[d][rl(d)-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input int d, input logic s, input logic e);
    core_start[d] = s;
    core_end[d]   = e;
  endtask

  // One complete access by one requester; checks latency, RAM strobe, data.
  task automatic access(input int d, input bit io, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    int lat, cnt, en0, w;
    bit seen_other;
    logic rdy;
    logic [31:0] exp_rd, got;
    lat    = wr ? 2 : 1 + rl(d);
    w      = int'((addr >> 2) & ((32'd1 << ADDR_W) - 1));
    exp_rd = shadow[d][w];
    en0    = en_cnt[d];
    if (io) begin
      memread_io[d] = rd; memwrite_io[d] = wr; addr_io[d] = addr; write_data_io[d] = wdata;
    end else begin
      memread_mem[d] = rd; memwrite_mem[d] = wr; alu_result_mem[d] = addr;
      write_data_memory_mem[d] = wdata;
    end
    cnt = 0;
    seen_other = 1'b0;
    do begin
      tick();
      cnt++;
      if (io ? (data_ready_mem[d] !== 1'b1) : (data_ready_io[d] !== 1'b0)) seen_other = 1'b1;
      rdy = io ? data_ready_io[d] : data_ready_mem[d];
    end while (rdy !== 1'b1 && cnt < 12);
    n_checks++;
    if (cnt != lat) begin
      n_errors++;
      $display("FAIL %s latency[%0d]: got %0d cycles, expected %0d", tag, d, cnt, lat);
    end
    n_checks++;
    if (seen_other) begin
      n_errors++;
      $display("FAIL %s other_ready[%0d]: other port's ready misbehaved, expected %s", tag, d,
               io ? "data_ready_mem held 1" : "data_ready_io held 0");
    end
    n_checks++;
    if (en_cnt[d] - en0 != 1 || last_we[d] !== wr || last_addr[d] !== ADDR_W'(w)) begin
      n_errors++;
      $display("FAIL %s ram_strobe[%0d]: got en=%0d we=%b addr=%h, expected en=1 we=%b addr=%h",
               tag, d, en_cnt[d] - en0, last_we[d], last_addr[d], wr, ADDR_W'(w));
    end
    if (wr) begin
      n_checks++;
      if (last_wdata[d] !== wdata) begin
        n_errors++;
        $display("FAIL %s ram_wdata[%0d]: got %h, expected %h", tag, d, last_wdata[d], wdata);
      end
      shadow[d][w] = wdata;
      written[d].push_back(w);
    end else begin
      got = io ? data_from_memory_io[d] : data_from_memory_mem[d];
      n_checks++;
      if (got !== exp_rd) begin
        n_errors++;
        $display("FAIL %s rdata[%0d]: got %h, expected %h", tag, d, got, exp_rd);
      end
    end
    memread_io[d] = 1'b0; memwrite_io[d] = 1'b0;
    memread_mem[d] = 1'b0; memwrite_mem[d] = 1'b0;
    tick();
    if (!wr) begin
      got = io ? data_from_memory_io[d] : data_from_memory_mem[d];
      n_checks++;
      if (got !== exp_rd) begin
        n_errors++;
        $display("FAIL %s rdata_hold[%0d]: got %h, expected %h", tag, d, got, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      set_window(d, 1'b0, 1'b0);
      memread_mem[d] = 1'b0; memwrite_mem[d] = 1'b0; alu_result_mem[d] = '0;
      write_data_memory_mem[d] = '0; memread_io[d] = 1'b0; memwrite_io[d] = 1'b0;
      addr_io[d] = '0; write_data_io[d] = '0;
    end
    #2;
    for (int d = 0; d < NI; d++) begin
      n_checks++;
      if ({ram_en[d], ram_we[d], data_ready_mem[d], data_ready_io[d]} !== 4'b0 ||
          data_from_memory_mem[d] !== '0 || data_from_memory_io[d] !== '0 ||
          ram_addr[d] !== '0 || ram_wdata[d] !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: en=%b we=%b rdym=%b rdyio=%b dm=%h dio=%h a=%h wd=%h, expected all 0",
                 d, ram_en[d], ram_we[d], data_ready_mem[d], data_ready_io[d],
                 data_from_memory_mem[d], data_from_memory_io[d], ram_addr[d], ram_wdata[d]);
      end
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < NI; d++) begin
      n_checks++;
      if (ram_en[d] !== 1'b0 || data_ready_mem[d] !== 1'b1 || data_ready_io[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_idle[%0d]: en=%b rdym=%b rdyio=%b, expected 0 1 0",
                 d, ram_en[d], data_ready_mem[d], data_ready_io[d]);
      end
    end
  endtask

  task automatic test_core_write_read();
    for (int d = 0; d < NI; d++) begin
      set_window(d, 1'b1, 1'b0);
      access(d, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "core_wr");
      access(d, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "core_rd");
    end
  endtask

  task automatic test_io_idle();
    for (int d = 0; d < NI; d++) begin
      set_window(d, 1'b0, 1'b0);
      access(d, 1'b1, 1'b0, 1'b1, 32'h4, $urandom, "io_wr");
      access(d, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, "io_rd");
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] lowmask;
    lowmask = (32'd1 << (ADDR_W + 2)) - 1;
    for (int i = 0; i < n; i++) begin
      bit io, rdf, wrf;
      logic [31:0] a, wd;
      int w;
      io = 1'($urandom_range(0, 1));
      if (io) begin
        if ($urandom_range(0, 1) == 0) set_window(d, 1'b0, 1'b0);
        else                           set_window(d, 1'b1, 1'b1);
      end else begin
        set_window(d, 1'b1, 1'b0);
      end
      wd = $urandom;
      if (written[d].size() > 0 && $urandom_range(0, 2) == 0) begin
        w   = written[d][$urandom_range(0, written[d].size() - 1)];
        a   = ($urandom & ~lowmask) | (32'(w) << 2) | ($urandom & 32'h3);
        rdf = 1'b1;
        wrf = 1'b0;
      end else begin
        a   = $urandom;
        rdf = ($urandom_range(0, 3) == 0);
        wrf = 1'b1;
      end
      access(d, io, rdf, wrf, a, wd, "random");
    end
  endtask

`ifndef DMEM_ARB_SHARED_EN
  task automatic test_hold_pending();
    int d, cnt, en0;
    bit early;
    logic [31:0] v;
    d = 0;
    v = $urandom;
    set_window(d, 1'b1, 1'b0);
    en0 = en_cnt[d];
    memwrite_io[d] = 1'b1; addr_io[d] = 32'h0000_0088; write_data_io[d] = v;
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_ready_io[d] !== 1'b0 || en_cnt[d] != en0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_errors++;
      $display("FAIL hold_pending: IO served during run window, expected held");
    end
    core_end[d] = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (data_ready_io[d] !== 1'b1 && cnt < 12);
    n_checks++;
    if (cnt != 2) begin
      n_errors++;
      $display("FAIL hold_release: got %0d cycles, expected 2", cnt);
    end
    shadow[d][34] = v;
    written[d].push_back(34);
    memwrite_io[d] = 1'b0;
    tick();
    access(d, 1'b1, 1'b1, 1'b0, 32'h0000_0088, 32'h0, "hold_readback");
  endtask
`else
  task automatic test_round_robin();
    int d, n, cnt;
    int order [3];
    d = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_window(d, 1'b1, 1'b0);
    memwrite_mem[d] = 1'b1; alu_result_mem[d] = 32'h40; write_data_memory_mem[d] = 32'h1111_2222;
    memwrite_io[d]  = 1'b1; addr_io[d]        = 32'h44; write_data_io[d]         = 32'h3333_4444;
    n = 0;
    cnt = 0;
    while (n < 3 && cnt < 40) begin
      tick();
      cnt++;
      if (data_ready_mem[d] === 1'b1) begin order[n] = 0; n++; end
      else if (data_ready_io[d] === 1'b1) begin order[n] = 1; n++; end
    end
    memwrite_mem[d] = 1'b0; memwrite_io[d] = 1'b0;
    tick();
    shadow[d][16] = 32'h1111_2222; written[d].push_back(16);
    shadow[d][17] = 32'h3333_4444; written[d].push_back(17);
    n_checks++;
    if (n != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      n_errors++;
      $display("FAIL rr_order: got %0d grants order %0d,%0d,%0d, expected core,io,core (0,1,0)",
               n, order[0], order[1], order[2]);
    end
  endtask
`endif

  task automatic test_core_end_mid();
    int d, cnt;
    d = 1;
    set_window(d, 1'b1, 1'b0);
    memread_mem[d] = 1'b1; alu_result_mem[d] = 32'h10;
    tick();
    core_end[d] = 1'b1;
    cnt = 1;
    while (data_ready_mem[d] !== 1'b1 && cnt < 12) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 1 + rl(d) || data_from_memory_mem[d] !== shadow[d][4]) begin
      n_errors++;
      $display("FAIL core_end_mid: got %0d cycles data %h, expected %0d cycles data %h",
               cnt, data_from_memory_mem[d], 1 + rl(d), shadow[d][4]);
    end
    memread_mem[d] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int d, en0;
    bit bad;
    logic [31:0] v;
    d = 1;
    v = $urandom;
    set_window(d, 1'b1, 1'b0);
    access(d, 1'b0, 1'b0, 1'b1, 32'h20, v, "rst_prep");
    memread_mem[d] = 1'b1; alu_result_mem[d] = 32'h20;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_en[d] !== 1'b0 || data_ready_mem[d] !== 1'b0 || data_ready_io[d] !== 1'b0 ||
        data_from_memory_mem[d] !== '0) begin
      n_errors++;
      $display("FAIL rst_in_wait: en=%b rdym=%b rdyio=%b dm=%h, expected 0 0 0 0",
               ram_en[d], data_ready_mem[d], data_ready_io[d], data_from_memory_mem[d]);
    end
    memread_mem[d] = 1'b0;
    tick();
    rst = 1'b0;
    en0 = en_cnt[d];
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (en_cnt[d] != en0 || data_from_memory_mem[d] !== '0 || data_ready_io[d] !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL rst_abort: aborted access resumed (en delta %0d, dm=%h), expected none",
               en_cnt[d] - en0, data_from_memory_mem[d]);
    end
    access(d, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, "post_rst_rd");
  endtask

  initial begin
    test_reset();
    test_core_write_read();
    test_io_idle();
    test_random(0, 30);
    test_random(1, 30);
`ifndef DMEM_ARB_SHARED_EN
    test_hold_pending();
`else
    test_round_robin();
`endif
    test_core_end_mid();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, word-address width; RD_LAT, default 1, RAM read latency in cycles (legal 1..3).
REQ-002 One clock and one reset SHALL be used; reset is asynchronous and active-high; ports are listed below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 core_start, core_end  in  1 each  core run window, level.
REQ-006 memread_mem, memwrite_mem  in  1 each  core MEM-stage request, held until data_ready_mem.
REQ-007 alu_result_mem, write_data_memory_mem  in  32 each  core byte address and write data.
REQ-008 data_from_memory_mem  out  32  core read data; data_ready_mem  out  1  core access done / no stall.
REQ-009 memread_io, memwrite_io  in  1 each  loader request, held until data_ready_io.
REQ-010 addr_io, write_data_io  in  32 each; data_from_memory_io  out  32; data_ready_io  out  1.
REQ-011 ram_en, ram_we  out  1 each; ram_addr  out  ADDR_W; ram_wdata  out  32; ram_rdata  in  32.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one access SHALL be in flight at a time.
REQ-013 IDLE: on an eligible request, latch owner, op, ram_addr = addr[ADDR_W+1:2] and wdata; go to ISSUE.
REQ-014 ISSUE: ram_en=1 for exactly one cycle, ram_we=1 for writes; writes go to RESP and reads go to WAIT, or to RESP when RD_LAT=1.
REQ-015 WAIT: count RD_LAT-1 cycles, then go to RESP; read data SHALL be captured from ram_rdata RD_LAT cycles after ISSUE.
REQ-016 RESP: assert the owner's data_ready for one cycle with the owner's read data valid, then go to IDLE.
REQ-017 Latency SHALL be: read = request seen in IDLE at cycle 0, data_ready at cycle 1+RD_LAT; write = data_ready at cycle 2.
REQ-018 data_ready_mem SHALL also be 1 whenever the core has no request and no core access is in flight, so the pipeline does not stall.
REQ-019 Eligibility: core requests only while core_start=1 and core_end=0; IO requests only outside that window.
REQ-020 Ineligible requests SHALL be held pending, not dropped; core_end rising mid core access SHALL let that access complete.
REQ-021 memread and memwrite both asserted by one requester SHALL be treated as a write.
REQ-022 Address bits above ADDR_W+1 SHALL be ignored (wrap); bits [1:0] SHALL be ignored.
REQ-023 data_from_memory_* SHALL hold the last read value until the next read by that owner completes.

Reset
REQ-024 rst SHALL force IDLE asynchronously; ram_en, ram_we, data_ready_mem and data_ready_io SHALL be 0; data outputs, ram_addr and ram_wdata SHALL be 0.
REQ-025 Reset mid-access SHALL abort the access with no data_ready pulse; the counter and owner SHALL clear.
REQ-026 The first cycle after reset release SHALL be IDLE with no grant.

Configuration
REQ-027 With macro DMEM_ARB_SHARED_EN defined, IO SHALL be eligible during the run window.
REQ-028 With DMEM_ARB_SHARED_EN, simultaneous eligible requests SHALL alternate round-robin (core first after reset); a lone requester is always granted.
REQ-029 Without DMEM_ARB_SHARED_EN, REQ-019 eligibility SHALL apply unchanged and no round-robin state SHALL exist.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state enum, the owner enum (OWN_CORE, OWN_IO) and the RD_LAT legality constants.
REQ-031 The latency counter SHALL be sub-module dmem_arb_lat_cnt (load, decrement, done); no other sub-modules.

Verification
REQ-032 RD_LAT=1, core running, core write addr 0x10 data 0xDEADBEEF: ram_we pulse with ram_addr=4; data_ready_mem at cycle 2.
REQ-033 Then core read 0x10: data_from_memory_mem=0xDEADBEEF and data_ready_mem at cycle 2; with RD_LAT=3, at cycle 4.
REQ-034 core_start=0, IO write 0x4 then read 0x4: data_ready_io pulses; no core grant; data_ready_mem=1 throughout.
REQ-035 Without the macro, IO request during run: held until core_end, then served; with the macro and simultaneous requests: grant order core, IO, core.
REQ-036 rst asserted during WAIT: ram_en=0 and no data_ready pulse; a post-reset read returns the RAM contents correctly.
